// File: rtl/wallace_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// wallace_mul_arbiter_if
// Bundles the signals between the requesters, the arbiter and the shared
// Wallace multiplier.
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake
//   hold                            : blocks new grants
//   mul_a/mul_b/mul_p               : multiplier operands and product
//   rsp_valid/rsp_id/rsp_p          : tagged product response
//   idle                            : nothing in flight, no response pending
// Modports: slave = arbiter side, master = requester/multiplier side.
// ---------------------------------------------------------------------------
interface wallace_mul_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 33,
   parameter int IDW   = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  hold;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic [2*WIDTH-2:0]    mul_p;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-2:0]    rsp_p;
   logic                  idle;

   modport slave (
      input  req_valid, req_a, req_b, hold, mul_p,
      output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, idle
   );

   modport master (
      output req_valid, req_a, req_b, hold, mul_p,
      input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, idle
   );
endinterface

// File: rtl/wallace_mul_arbiter.sv
// ---------------------------------------------------------------------------
// wallace_mul_arbiter
// Round-robin arbiter and issue sequencer sharing one pipelined signed
// Wallace multiplier among NREQ requesters. One operand pair is accepted per
// cycle, registered onto mul_a/mul_b, and its requester ID rides a tag
// pipeline matching the multiplier latency so the product returns tagged.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : wallace_mul_arbiter_if.slave (handshake, multiplier, response)
// ---------------------------------------------------------------------------
module wallace_mul_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 33,
   parameter int LAT   = 3,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   wallace_mul_arbiter_if.slave  bus
);

   localparam int PW = 2*WIDTH-1;

   logic [IDW-1:0]   ptr;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_id;
   logic             found;
   logic [IDW:0]     cand;
   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   logic [WIDTH-1:0] mul_a_q;
   logic [WIDTH-1:0] mul_b_q;
   logic [LAT:0]     tag_v;
   logic [IDW-1:0]   tag_id [0:LAT];
   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [PW-1:0]    rsp_p_q;

   // Scan from ptr+1 upward with wrap; the sum never exceeds 2*NREQ-1 so a
   // single conditional subtract implements the modulo.
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      cand     = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = {1'b0, ptr} + (IDW+1)'(off);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!found && bus.req_valid[cand[IDW-1:0]]) begin
            found    = 1'b1;
            grant_id = cand[IDW-1:0];
         end
      end
   end

   // Grant is suppressed while hold is high or reset is asserted.
   always_comb begin
      grant = '0;
      if (found && !bus.hold && rst) begin
         grant = NREQ'(1) << grant_id;
      end
   end

   assign accept = |grant;

   // One-hot operand mux driven by the grant vector.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            sel_a = sel_a | bus.req_a[k*WIDTH +: WIDTH];
            sel_b = sel_b | bus.req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   // Operand registers and round-robin pointer update on accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr     <= IDW'(NREQ-1);
         mul_a_q <= '0;
         mul_b_q <= '0;
      end else if (accept) begin
         ptr     <= grant_id;
         mul_a_q <= sel_a;
         mul_b_q <= sel_b;
      end
   end

   // Tag pipeline: never stalls because the multiplier cannot be
   // back-pressured. Stage 0 id is a don't-care when no accept occurs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_v <= '0;
         for (int s = 0; s <= LAT; s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         tag_v     <= {tag_v[LAT-1:0], accept};
         tag_id[0] <= grant_id;
         for (int s = 1; s <= LAT; s++) begin
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   // Response register; the product is captured only for a valid tag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_p_q     <= '0;
      end else begin
         rsp_valid_q <= tag_v[LAT];
         rsp_id_q    <= tag_id[LAT];
         if (tag_v[LAT]) begin
            rsp_p_q <= bus.mul_p;
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_p     = rsp_p_q;
   assign bus.idle      = ~(|tag_v | rsp_valid_q);

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wallace_mul_arbiter
// Directed bench for wallace_mul_arbiter with a behavioural LAT-deep signed
// multiplier. Issued operations push hand-computed expected responses into
// a queue; a negedge monitor pops and compares each response.
// ---------------------------------------------------------------------------
module tb_wallace_mul_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 33;
   localparam int LAT   = 3;
   localparam int IDW   = 2;
   localparam int PW    = 2*WIDTH-1;

   typedef struct {
      logic [IDW-1:0] id;
      logic [PW-1:0]  p;
      int             due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb [$];

   logic signed [WIDTH-1:0] op_a [NREQ];
   logic signed [WIDTH-1:0] op_b [NREQ];
   logic [PW-1:0]           op_p [NREQ];
   logic [PW-1:0]           mpipe [0:LAT-1];

   wallace_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   wallace_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Behavioural multiplier: full product, truncated to 2*WIDTH-1 bits.
   always @(posedge clk) begin
      logic signed [2*WIDTH-1:0] full;
      full = $signed({{WIDTH{bus.mul_a[WIDTH-1]}}, bus.mul_a}) *
             $signed({{WIDTH{bus.mul_b[WIDTH-1]}}, bus.mul_b});
      mpipe[0] <= full[PW-1:0];
      for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
   end
   assign bus.mul_p = mpipe[LAT-1];

   task automatic check_output(input string name, input logic [PW-1:0] act,
                               input logic [PW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic set_op(input int k, input logic signed [WIDTH-1:0] a,
                         input logic signed [WIDTH-1:0] b, input logic [PW-1:0] p);
      op_a[k] = a;
      op_b[k] = b;
      op_p[k] = p;
      bus.req_a[k*WIDTH +: WIDTH] = a;
      bus.req_b[k*WIDTH +: WIDTH] = b;
   endtask

   // Drive one cycle of requests, check the grant and queue the expected
   // response for the requester that should have won.
   task automatic apply_stimulus(input logic [NREQ-1:0] valid, input logic h,
                                 input logic [NREQ-1:0] exp_grant, input string name);
      exp_t e;
      @(negedge clk);
      bus.req_valid = valid;
      bus.hold      = h;
      #1;
      check_output(name, PW'(bus.req_ready), PW'(exp_grant));
      for (int k = 0; k < NREQ; k++) begin
         if (exp_grant[k]) begin
            e.id  = IDW'(k);
            e.p   = op_p[k];
            e.due = cyc + LAT + 2;
            sb.push_back(e);
         end
      end
   endtask

   // Response monitor.
   always @(negedge clk) begin
      exp_t e;
      if (bus.rsp_valid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_rsp: got id %0d p %0h expected no response", bus.rsp_id, bus.rsp_p);
         end else begin
            e = sb.pop_front();
            check_output("rsp_id", PW'(bus.rsp_id), PW'(e.id));
            check_output("rsp_p", bus.rsp_p, e.p);
            check_output("rsp_cycle", PW'(cyc), PW'(e.due));
         end
      end
   end

   initial begin
      int last_rsp;
      int first_idle;
      logic [NREQ-1:0] rr [8];
      rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      bus.req_valid = '1;
      bus.hold      = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      for (int k = 0; k < NREQ; k++) set_op(k, '0, '0, '0);

      // Reset state
      #12;
      check_output("reset_ready", PW'(bus.req_ready), '0);
      check_output("reset_rsp_valid", PW'(bus.rsp_valid), '0);
      check_output("reset_idle", PW'(bus.idle), PW'(1));
      check_output("reset_mul_a", PW'(bus.mul_a), '0);
      check_output("reset_rsp_p", bus.rsp_p, '0);
      bus.req_valid = '0;
      rst = 1'b1;

      // Single, large, signed and extreme operand requests
      set_op(0, 33'sd19, 33'sd15, 65'd285);
      apply_stimulus(4'b0001, 1'b0, 4'b0001, "single_grant");
      apply_stimulus(4'b0000, 1'b0, 4'b0000, "gap");
      set_op(2, 33'sd9943000, 33'sd3302367, 65'd32835435081000);
      apply_stimulus(4'b0100, 1'b0, 4'b0100, "large_grant");
      set_op(1, -33'sd7, 33'sd6, -65'sd42);
      apply_stimulus(4'b0010, 1'b0, 4'b0010, "signed_grant");
      set_op(3, 33'h1_0000_0000, 33'h1_0000_0000, 65'h1_0000_0000_0000_0000);
      apply_stimulus(4'b1000, 1'b0, 4'b1000, "extreme_grant");
      apply_stimulus(4'b0000, 1'b0, 4'b0000, "gap");

      // All requesters valid: round-robin 0,1,2,3,0,1,2,3
      set_op(0, 33'sd2, -33'sd3, -65'sd6);
      set_op(1, 33'sd3, -33'sd4, -65'sd12);
      set_op(2, 33'sd4, -33'sd5, -65'sd20);
      set_op(3, 33'sd5, -33'sd6, -65'sd30);
      for (int i = 0; i < 8; i++) apply_stimulus(4'b1111, 1'b0, rr[i], "rr_grant");
      apply_stimulus(4'b0000, 1'b0, 4'b0000, "gap");
      repeat (6) @(negedge clk);

      // Three in flight, then hold: no grants, responses drain, idle follows
      for (int i = 0; i < 3; i++) apply_stimulus(4'b1111, 1'b0, rr[i], "pre_hold_grant");
      last_rsp   = -1;
      first_idle = -1;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(4'b1111, 1'b1, 4'b0000, "hold_grant");
         if (bus.rsp_valid) last_rsp = cyc;
         if (bus.idle && first_idle < 0) first_idle = cyc;
      end
      check_output("idle_after_last_rsp", PW'(first_idle), PW'(last_rsp + 1));
      check_output("hold_drained", PW'(sb.size()), '0);

      // Async reset mid-clock with two operations in flight
      apply_stimulus(4'b0001, 1'b0, 4'b0001, "pre_reset_grant0");
      apply_stimulus(4'b0010, 1'b0, 4'b0010, "pre_reset_grant1");
      bus.req_valid = '1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_output("async_rsp_valid", PW'(bus.rsp_valid), '0);
      check_output("async_idle", PW'(bus.idle), PW'(1));
      check_output("async_ready", PW'(bus.req_ready), '0);
      check_output("async_mul_a", PW'(bus.mul_a), '0);
      sb.delete();
      bus.req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      apply_stimulus(4'b1111, 1'b0, 4'b0001, "post_reset_grant");
      apply_stimulus(4'b0000, 1'b0, 4'b0000, "gap");

      repeat (10) @(negedge clk);
      check_output("final_drained", PW'(sb.size()), '0);
      check_output("final_idle", PW'(bus.idle), PW'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
